counter_sequencer: RTL and testbench

COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

---
 rtl/counter_sequencer.sv | 117 +++++++++++
 tb/tb_counter_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// Sequencer for an external up/down counter: clears it, runs it for a
// commanded number of terminal-count passes, and reports completion or abort.
module counter_sequencer #(
  parameter int unsigned PASS_W       = 8,
  parameter int unsigned CLEAR_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [PASS_W-1:0] cmd_passes,
  input  logic              abort,
  output logic              cnt_enable,
  output logic              cnt_up0_dn1,
  output logic              cnt_clear,
  input  logic              cnt_done,
  output logic              busy,
  output logic [PASS_W-1:0] pass_count,
  output logic              seq_done,
  output logic              seq_aborted
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, FINISH} state_t;

  localparam logic [1:0] CLR_LAST = 2'(CLEAR_CYCLES - 1);

  state_t              state_q;
  logic [1:0]          clr_cnt_q;
  logic [PASS_W-1:0]   passes_q;
  logic [PASS_W-1:0]   pass_count_q;
  logic                done_prev_q;
  logic                cnt_enable_q;
  logic                cnt_clear_q;
  logic                cnt_up0_dn1_q;
  logic                seq_done_q;
  logic                seq_aborted_q;

  logic                done_rise_d;
  logic                last_pass_d;

  assign done_rise_d = cnt_done & ~done_prev_q;
  // passes_q == 0 wraps to all-ones here, giving 2^PASS_W passes
  assign last_pass_d = (pass_count_q == passes_q - PASS_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      clr_cnt_q     <= '0;
      passes_q      <= '0;
      pass_count_q  <= '0;
      done_prev_q   <= 1'b0;
      cnt_enable_q  <= 1'b0;
      cnt_clear_q   <= 1'b0;
      cnt_up0_dn1_q <= 1'b0;
      seq_done_q    <= 1'b0;
      seq_aborted_q <= 1'b0;
    end else begin
      done_prev_q   <= cnt_done;
      seq_done_q    <= 1'b0;
      seq_aborted_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            state_q       <= CLEAR;
            passes_q      <= cmd_passes;
            cnt_up0_dn1_q <= cmd_dir;
            pass_count_q  <= '0;
            clr_cnt_q     <= '0;
            cnt_clear_q   <= 1'b1;
            cnt_enable_q  <= 1'b1;
          end
        end
        CLEAR: begin
          if (abort) begin
            state_q       <= IDLE;
            cnt_enable_q  <= 1'b0;
            cnt_clear_q   <= 1'b0;
            seq_aborted_q <= 1'b1;
          end else if (clr_cnt_q == CLR_LAST) begin
            state_q     <= RUN;
            cnt_clear_q <= 1'b0;
          end else begin
            clr_cnt_q <= clr_cnt_q + 2'd1;
          end
        end
        RUN: begin
          // abort takes priority over a coincident final pass
          if (abort) begin
            state_q       <= IDLE;
            cnt_enable_q  <= 1'b0;
            seq_aborted_q <= 1'b1;
          end else if (done_rise_d) begin
            pass_count_q <= pass_count_q + PASS_W'(1);
            if (last_pass_d) begin
              state_q      <= FINISH;
              cnt_enable_q <= 1'b0;
              seq_done_q   <= 1'b1;
            end
          end
        end
        FINISH: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign cnt_enable  = cnt_enable_q;
  assign cnt_clear   = cnt_clear_q;
  assign cnt_up0_dn1 = cnt_up0_dn1_q;
  assign pass_count  = pass_count_q;
  assign seq_done    = seq_done_q;
  assign seq_aborted = seq_aborted_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: directed scenarios plus a randomized run
// checked cycle by cycle against a timeline-based reference model.
module tb_counter_sequencer;

  localparam int unsigned PASS_W       = 8;
  localparam int unsigned CLEAR_CYCLES = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_dir = 1'b0;
  logic [PASS_W-1:0] cmd_passes = '0;
  logic              abort = 1'b0;
  logic              cnt_enable;
  logic              cnt_up0_dn1;
  logic              cnt_clear;
  logic              cnt_done = 1'b0;
  logic              busy;
  logic [PASS_W-1:0] pass_count;
  logic              seq_done;
  logic              seq_aborted;

  int vectors = 0;
  int errors  = 0;

  counter_sequencer #(.PASS_W(PASS_W), .CLEAR_CYCLES(CLEAR_CYCLES)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_passes(cmd_passes), .abort(abort),
    .cnt_enable(cnt_enable), .cnt_up0_dn1(cnt_up0_dn1), .cnt_clear(cnt_clear),
    .cnt_done(cnt_done), .busy(busy), .pass_count(pass_count),
    .seq_done(seq_done), .seq_aborted(seq_aborted)
  );

  always #5 clk = ~clk;

  // Reference model: a sequence is described by its age since acceptance,
  // the number of counted edges and the target pass total.
  bit m_active, m_fin, m_prev, m_dir, m_abort_pulse;
  int m_age, m_count, m_target;

  task automatic model_reset();
    m_active = 0; m_fin = 0; m_prev = 0; m_dir = 0; m_abort_pulse = 0;
    m_age = 0; m_count = 0; m_target = 0;
  endtask

  task automatic model_edge();
    bit rise;
    rise = cnt_done && !m_prev;
    m_prev = cnt_done;
    m_abort_pulse = 0;
    if (m_fin) m_fin = 0;
    else if (m_active) begin
      if (abort) begin
        m_active = 0;
        m_abort_pulse = 1;
      end else begin
        if (m_age >= int'(CLEAR_CYCLES) && rise) begin
          m_count++;
          if (m_count == m_target) begin
            m_active = 0;
            m_fin = 1;
          end
        end
        m_age++;
      end
    end else if (cmd_valid) begin
      m_active = 1; m_age = 0; m_count = 0; m_dir = cmd_dir;
      m_target = (cmd_passes == 0) ? (1 << PASS_W) : int'(cmd_passes);
    end
  endtask

  function automatic logic [PASS_W+6:0] model_outputs();
    logic [PASS_W-1:0] pc;
    logic b;
    pc = PASS_W'(m_count % (1 << PASS_W));
    b  = m_active || m_fin;
    return {!b, b, m_active, m_active && (m_age < int'(CLEAR_CYCLES)), m_dir, pc,
            m_fin, m_abort_pulse};
  endfunction

  task automatic tick(input logic v, input logic d, input logic [PASS_W-1:0] p,
                      input logic a, input logic dn);
    cmd_valid = v; cmd_dir = d; cmd_passes = p; abort = a; cnt_done = dn;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_valid = 0; abort = 0; cnt_done = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({cmd_ready, busy, cnt_enable, cnt_clear, cnt_up0_dn1, pass_count, seq_done, seq_aborted}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {PASS_W{1'b0}}, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b busy=%b en=%b clr=%b dir=%b pc=%0d done=%b ab=%b, want 1 0 0 0 0 0 0 0",
               cmd_ready, busy, cnt_enable, cnt_clear, cnt_up0_dn1, pass_count, seq_done, seq_aborted);
    end
    tick(1, 0, 8'd1, 0, 0);
    vectors++;
    if (busy !== 1'b1) begin errors++; $display("FAIL first_cmd_accept: busy=%b want 1", busy); end
    tick(0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 0);
  endtask

  task automatic test_basic_up();
    tick(1, 0, 8'd3, 0, 0);
    vectors++;
    if ({busy, cmd_ready, cnt_enable, cnt_clear} !== 4'b1011) begin
      errors++; $display("FAIL basic_clear: busy/rdy/en/clr=%b want 1011", {busy, cmd_ready, cnt_enable, cnt_clear});
    end
    tick(0, 0, 0, 0, 0);
    vectors++;
    if ({cnt_enable, cnt_clear, cnt_up0_dn1} !== 3'b100) begin
      errors++; $display("FAIL basic_run: en/clr/dir=%b want 100", {cnt_enable, cnt_clear, cnt_up0_dn1});
    end
    for (int k = 1; k <= 3; k++) begin
      tick(0, 0, 0, 0, 1);
      vectors++;
      if (pass_count !== PASS_W'(k) || seq_done !== (k == 3)) begin
        errors++; $display("FAIL basic_pass%0d: pc=%0d done=%b want pc=%0d done=%b", k, pass_count, seq_done, k, k == 3);
      end
      if (k < 3) tick(0, 0, 0, 0, 0);
    end
    vectors++;
    if ({cnt_enable, busy} !== 2'b01) begin
      errors++; $display("FAIL basic_finish: en/busy=%b want 01", {cnt_enable, busy});
    end
    tick(0, 0, 0, 0, 0);
    vectors++;
    if ({seq_done, busy, cmd_ready, pass_count} !== {3'b001, 8'd3}) begin
      errors++; $display("FAIL basic_idle: done/busy/rdy=%b pc=%0d want 001 pc=3", {seq_done, busy, cmd_ready}, pass_count);
    end
  endtask

  task automatic test_level_vs_edge();
    tick(1, 1, 8'd3, 0, 1);
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    vectors++;
    if (pass_count !== 8'd0) begin errors++; $display("FAIL level_on_entry: pc=%0d want 0", pass_count); end
    tick(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, 1);
    vectors++;
    if (pass_count !== 8'd1 || cnt_up0_dn1 !== 1'b1) begin
      errors++; $display("FAIL level_held: pc=%0d dir=%b want pc=1 dir=1", pass_count, cnt_up0_dn1);
    end
    tick(0, 0, 0, 1, 0);
    vectors++;
    if ({seq_aborted, busy, cnt_enable, pass_count} !== {3'b100, 8'd1}) begin
      errors++; $display("FAIL level_abort: ab/busy/en=%b pc=%0d want 100 pc=1", {seq_aborted, busy, cnt_enable}, pass_count);
    end
    tick(0, 0, 0, 0, 0);
  endtask

  task automatic test_abort_collision();
    tick(1, 0, 8'd2, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 1);
    vectors++;
    if ({seq_aborted, seq_done, busy, pass_count} !== {3'b100, 8'd1}) begin
      errors++; $display("FAIL abort_collision: ab/done/busy=%b pc=%0d want 100 pc=1", {seq_aborted, seq_done, busy}, pass_count);
    end
    tick(0, 0, 0, 0, 0);
    vectors++;
    if ({seq_aborted, seq_done} !== 2'b00) begin
      errors++; $display("FAIL abort_pulse_len: ab/done=%b want 00", {seq_aborted, seq_done});
    end
  endtask

  task automatic test_busy_reject();
    tick(1, 1, 8'd2, 0, 0);
    tick(0, 1, 0, 0, 0);
    tick(1, 0, 8'd7, 0, 1);
    vectors++;
    if (pass_count !== 8'd1 || cnt_up0_dn1 !== 1'b1) begin
      errors++; $display("FAIL busy_reject_dir: pc=%0d dir=%b want pc=1 dir=1", pass_count, cnt_up0_dn1);
    end
    tick(1, 0, 8'd7, 0, 0);
    tick(1, 0, 8'd7, 0, 1);
    vectors++;
    if (seq_done !== 1'b1 || pass_count !== 8'd2) begin
      errors++; $display("FAIL busy_reject_done: done=%b pc=%0d want done=1 pc=2", seq_done, pass_count);
    end
  endtask

  task automatic test_back_to_back();
    // previous task left the block in FINISH with cmd_valid still asserted
    tick(1, 0, 8'd1, 0, 0);
    vectors++;
    if ({busy, cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL finish_ignores_cmd: busy/rdy=%b want 01", {busy, cmd_ready});
    end
    tick(1, 0, 8'd1, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1);
    vectors++;
    if (seq_done !== 1'b1) begin errors++; $display("FAIL b2b_first_done: done=%b want 1", seq_done); end
    tick(0, 0, 0, 0, 0);
    tick(1, 1, 8'd1, 0, 0);
    vectors++;
    if ({busy, cnt_clear, pass_count} !== {2'b11, 8'd0}) begin
      errors++; $display("FAIL b2b_accept: busy/clr=%b pc=%0d want 11 pc=0", {busy, cnt_clear}, pass_count);
    end
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0);
  endtask

  task automatic test_wrap();
    int early;
    early = 0;
    tick(1, 0, 8'd0, 0, 0);
    tick(0, 0, 0, 0, 0);
    for (int k = 1; k <= 256; k++) begin
      tick(0, 0, 0, 0, 1);
      if (k < 256 && seq_done) early++;
      if (k < 256) tick(0, 0, 0, 0, 0);
    end
    vectors++;
    if (early != 0) begin errors++; $display("FAIL wrap_early_done: %0d early pulses want 0", early); end
    vectors++;
    if (seq_done !== 1'b1 || pass_count !== 8'd0) begin
      errors++; $display("FAIL wrap_final: done=%b pc=%0d want done=1 pc=0", seq_done, pass_count);
    end
    tick(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    pulses = 0;
    tick(1, 1, 8'd9, 0, 0);
    tick(0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      tick(0, 0, 0, 0, 1);
      tick(0, 0, 0, 0, 0);
    end
    vectors++;
    if (pass_count !== 8'd4) begin errors++; $display("FAIL midrun_setup: pc=%0d want 4", pass_count); end
    #1 rst = 1'b1;
    model_reset();
    #1;
    vectors++;
    if ({cmd_ready, busy, cnt_enable, cnt_clear, cnt_up0_dn1, pass_count, seq_done, seq_aborted}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {PASS_W{1'b0}}, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midrun_reset: got rdy=%b busy=%b en=%b clr=%b dir=%b pc=%0d done=%b ab=%b, want 1 0 0 0 0 0 0 0",
               cmd_ready, busy, cnt_enable, cnt_clear, cnt_up0_dn1, pass_count, seq_done, seq_aborted);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (seq_done || seq_aborted) pulses++;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    if (seq_done || seq_aborted) pulses++;
    vectors++;
    if (pulses != 0) begin errors++; $display("FAIL midrun_pulses: %0d pulses want 0", pulses); end
  endtask

  task automatic test_random();
    logic [PASS_W+6:0] got, exp;
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 3) == 0), 1'($urandom), PASS_W'($urandom_range(1, 5)),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0));
      got = {cmd_ready, busy, cnt_enable, cnt_clear, cnt_up0_dn1, pass_count, seq_done, seq_aborted};
      exp = model_outputs();
      vectors++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_cycle%0d: {rdy,busy,en,clr,dir,pc,done,ab}=%h want %h", i, got, exp);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_up();
    test_level_vs_edge();
    test_abort_collision();
    test_busy_reject();
    test_back_to_back();
    test_wrap();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
